reg_file_sb: RTL and testbench



---
 rtl/reg_file_sb_if.sv | 29 ++
 rtl/reg_file_sb.sv | 117 +++++++++++
 tb/tb_reg_file_sb.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// Operand-read, writeback and issue signals between the decode stage and reg_file_sb.
// The master drives addresses, data and strobes; the slave returns operands and busy flags.
interface reg_file_sb_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic [WIDTH-1:0] wr;
  logic [AW-1:0]    wa;
  logic             wren;
  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rr1;
  logic [WIDTH-1:0] rr2;
  logic             iss_en;
  logic [AW-1:0]    iss_a;
  logic             busy1;
  logic             busy2;
  logic [AW:0]      nbusy;

  modport master (
    output wr, wa, wren, ra1, ra2, iss_en, iss_a,
    input  rr1, rr2, busy1, busy2, nbusy
  );

  modport slave (
    input  wr, wa, wren, ra1, ra2, iss_en, iss_a,
    output rr1, rr2, busy1, busy2, nbusy
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port (active-low enable)
// and a per-register pending-write scoreboard with a population count of busy entries.
module reg_file_sb #(
  parameter int WIDTH   = 32,
  parameter int AW      = 5,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic          clk,
  input  logic          rstd,
  reg_file_sb_if.slave  bus
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] rf_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [AW:0]      nbusy_q;
  logic [AW:0]      nbusy_d;

  logic             wr_en_s;
  logic             iss_en_s;
  logic             byp_s;
  logic [WIDTH-1:0] rr1_s;
  logic [WIDTH-1:0] rr2_s;
  logic             busy1_s;
  logic             busy2_s;

  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] c;
    c = {(AW+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_R0 != 0) && (a == {AW{1'b0}});
  endfunction

  assign wr_en_s  = !bus.wren && !is_zero_reg(bus.wa);
  assign iss_en_s = bus.iss_en && !is_zero_reg(bus.iss_a);
  // Forwarding is suppressed while reset is held so the read ports show zero.
  assign byp_s    = (BYPASS != 0) && !bus.wren && rstd;

  // Next busy vector: writeback clears, issue sets; issue wins on a shared address.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_s) begin
      busy_d[bus.wa] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (iss_en_s) begin
      busy_d[bus.iss_a] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    nbusy_d = popcount(busy_d);
  end

  // Register array, busy bits and busy count.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_q[i] <= {WIDTH{1'b0}};
      end
      busy_q  <= {DEPTH{1'b0}};
      nbusy_q <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        rf_q[bus.wa] <= bus.wr;
      end
      busy_q  <= busy_d;
      nbusy_q <= nbusy_d;
    end
  end

  // Read port 1: zero register, then same-cycle forward, then stored state.
  always_comb begin
    rr1_s   = rf_q[bus.ra1];
    busy1_s = busy_q[bus.ra1];
    if (is_zero_reg(bus.ra1)) begin
      rr1_s   = {WIDTH{1'b0}};
      busy1_s = 1'b0;
    end else if (byp_s && (bus.wa == bus.ra1)) begin
      rr1_s   = bus.wr;
      busy1_s = 1'b0;
    end else begin
      rr1_s   = rf_q[bus.ra1];
      busy1_s = busy_q[bus.ra1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rr2_s   = rf_q[bus.ra2];
    busy2_s = busy_q[bus.ra2];
    if (is_zero_reg(bus.ra2)) begin
      rr2_s   = {WIDTH{1'b0}};
      busy2_s = 1'b0;
    end else if (byp_s && (bus.wa == bus.ra2)) begin
      rr2_s   = bus.wr;
      busy2_s = 1'b0;
    end else begin
      rr2_s   = rf_q[bus.ra2];
      busy2_s = busy_q[bus.ra2];
    end
  end

  assign bus.rr1   = rr1_s;
  assign bus.rr2   = rr2_s;
  assign bus.busy1 = busy1_s;
  assign bus.busy2 = busy2_s;
  assign bus.nbusy = nbusy_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: three instances (bypass, no bypass, narrow without
// a zero register) with expected values queued at stimulus time and popped at sampling.
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rstd;

  always #5 clk = ~clk;

  reg_file_sb_if #(.WIDTH(32), .AW(5)) if0 ();
  reg_file_sb_if #(.WIDTH(32), .AW(5)) if1 ();
  reg_file_sb_if #(.WIDTH(16), .AW(3)) if2 ();

  reg_file_sb #(.WIDTH(32), .AW(5), .BYPASS(1), .ZERO_R0(1)) u_byp (
    .clk(clk), .rstd(rstd), .bus(if0.slave));
  reg_file_sb #(.WIDTH(32), .AW(5), .BYPASS(0), .ZERO_R0(1)) u_nobyp (
    .clk(clk), .rstd(rstd), .bus(if1.slave));
  reg_file_sb #(.WIDTH(16), .AW(3), .BYPASS(1), .ZERO_R0(0)) u_small (
    .clk(clk), .rstd(rstd), .bus(if2.slave));

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow: observed %h expected <queued entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // Drive the two 32-bit instances identically.
  task automatic drv01(input logic wren, input logic [4:0] wa, input logic [31:0] wr,
                       input logic iss_en, input logic [4:0] iss_a,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    if0.wren = wren; if0.wa = wa; if0.wr = wr; if0.iss_en = iss_en; if0.iss_a = iss_a;
    if0.ra1 = ra1; if0.ra2 = ra2;
    if1.wren = wren; if1.wa = wa; if1.wr = wr; if1.iss_en = iss_en; if1.iss_a = iss_a;
    if1.ra1 = ra1; if1.ra2 = ra2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] f2val(input int i);
    return 16'((i + 1) * 32'h0000_1357);
  endfunction

  initial begin
    rstd = 1'b0;
    drv01(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    if2.wren = 1'b1; if2.wa = 3'd0; if2.wr = 16'h0; if2.iss_en = 1'b0; if2.iss_a = 3'd0;
    if2.ra1 = 3'd0; if2.ra2 = 3'd7;
    push("rst_rr1", 32'h0); push("rst_busy1", 32'h0); push("rst_nbusy", 32'h0);
    push("rst_small_rr2", 32'h0); push("rst_small_nbusy", 32'h0);
    #2;
    pop_chk(if0.rr1); pop_chk(32'(if0.busy1)); pop_chk(32'(if0.nbusy));
    pop_chk(32'(if2.rr2)); pop_chk(32'(if2.nbusy));
    #10 rstd = 1'b1;

    // Write r3 then r4, then a disabled write to r3.
    drv01(1'b0, 5'd3, 32'haaaaaaaa, 1'b0, 5'd0, 5'd3, 5'd4);
    step();
    drv01(1'b0, 5'd4, 32'h55555555, 1'b0, 5'd0, 5'd3, 5'd4);
    step();
    drv01(1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 5'd3, 5'd4);
    push("rd_r3", 32'haaaaaaaa); push("rd_r4", 32'h55555555);
    #1;
    pop_chk(if0.rr1); pop_chk(if0.rr2);
    step();
    push("wren_hi_r3", 32'haaaaaaaa);
    pop_chk(if0.rr1);

    // Zero register: write and issue r0.
    drv01(1'b0, 5'd0, 32'hffffffff, 1'b1, 5'd0, 5'd0, 5'd0);
    push("r0_no_bypass", 32'h0);
    #1;
    pop_chk(if0.rr1);
    step();
    drv01(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    push("r0_rr1", 32'h0); push("r0_busy1", 32'h0); push("r0_nbusy", 32'h0);
    #1;
    pop_chk(if0.rr1); pop_chk(32'(if0.busy1)); pop_chk(32'(if0.nbusy));

    // Write and issue r5 together, then bypass a new value into r5.
    drv01(1'b0, 5'd5, 32'hdeadbeef, 1'b1, 5'd5, 5'd5, 5'd5);
    step();
    drv01(1'b0, 5'd5, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd5);
    push("byp_rr1", 32'h12345678); push("byp_busy1", 32'h0);
    push("nobyp_rr1_old", 32'hdeadbeef); push("nobyp_busy1", 32'h1);
    push("r5_nbusy", 32'h1);
    #1;
    pop_chk(if0.rr1); pop_chk(32'(if0.busy1));
    pop_chk(if1.rr1); pop_chk(32'(if1.busy1)); pop_chk(32'(if0.nbusy));
    step();
    drv01(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    push("byp_after", 32'h12345678); push("nobyp_after", 32'h12345678);
    push("nobyp_busy_clr", 32'h0); push("nobyp_nbusy", 32'h0);
    #1;
    pop_chk(if0.rr1); pop_chk(if1.rr1); pop_chk(32'(if1.busy1)); pop_chk(32'(if1.nbusy));

    // Scoreboard: issue r6, r7, r6 again.
    drv01(1'b1, 5'd0, 32'h0, 1'b1, 5'd6, 5'd6, 5'd7);
    step();
    drv01(1'b1, 5'd0, 32'h0, 1'b1, 5'd7, 5'd6, 5'd7);
    step();
    drv01(1'b1, 5'd0, 32'h0, 1'b1, 5'd6, 5'd6, 5'd7);
    step();
    drv01(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd7);
    push("sb_nbusy2", 32'h2); push("sb_busy6", 32'h1); push("sb_busy7", 32'h1);
    #1;
    pop_chk(32'(if0.nbusy)); pop_chk(32'(if0.busy1)); pop_chk(32'(if0.busy2));

    // Write r6 while issuing r8.
    drv01(1'b0, 5'd6, 32'h66666666, 1'b1, 5'd8, 5'd6, 5'd8);
    step();
    drv01(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd8);
    push("wr6_iss8_nbusy", 32'h2); push("busy6_clr", 32'h0);
    push("busy8_set", 32'h1); push("rd_r6", 32'h66666666);
    #1;
    pop_chk(32'(if0.nbusy)); pop_chk(32'(if0.busy1)); pop_chk(32'(if0.busy2));
    pop_chk(if0.rr1);

    // Write and issue r9 in the same cycle.
    drv01(1'b0, 5'd9, 32'h99999999, 1'b1, 5'd9, 5'd9, 5'd9);
    step();
    drv01(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd3);
    push("r9_busy", 32'h1); push("r9_data", 32'h99999999);
    push("r9_nbusy", 32'h3); push("r9_nobyp_nbusy", 32'h3);
    #1;
    pop_chk(32'(if0.busy1)); pop_chk(if0.rr1); pop_chk(32'(if0.nbusy)); pop_chk(32'(if1.nbusy));

    // Mid-cycle asynchronous reset with state present.
    #2 rstd = 1'b0;
    push("arst_rr1", 32'h0); push("arst_rr2", 32'h0);
    push("arst_busy1", 32'h0); push("arst_nbusy", 32'h0);
    #1;
    pop_chk(if0.rr1); pop_chk(if0.rr2); pop_chk(32'(if0.busy1)); pop_chk(32'(if0.nbusy));
    step();
    #2 rstd = 1'b1;
    step();
    push("post_rst_r3", 32'h0); push("post_rst_nbusy", 32'h0);
    pop_chk(if0.rr2); pop_chk(32'(if0.nbusy));

    // Narrow instance: fill, read back, issue all, clear all.
    for (int i = 0; i < 8; i++) begin
      if2.wren = 1'b0; if2.wa = 3'(i); if2.wr = f2val(i);
      step();
    end
    if2.wren = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if2.ra1 = 3'(i); if2.ra2 = 3'(7 - i);
      push("small_rd1", 32'(f2val(i))); push("small_rd2", 32'(f2val(7 - i)));
      #1;
      pop_chk(32'(if2.rr1)); pop_chk(32'(if2.rr2));
    end
    for (int i = 0; i < 8; i++) begin
      if2.iss_en = 1'b1; if2.iss_a = 3'(i);
      step();
    end
    if2.iss_en = 1'b0; if2.ra1 = 3'd0;
    push("small_nbusy_full", 32'h8); push("small_busy_r0", 32'h1);
    #1;
    pop_chk(32'(if2.nbusy)); pop_chk(32'(if2.busy1));
    for (int i = 0; i < 8; i++) begin
      if2.wren = 1'b0; if2.wa = 3'(i); if2.wr = f2val(i);
      step();
    end
    if2.wren = 1'b1;
    push("small_nbusy_empty", 32'h0);
    #1;
    pop_chk(32'(if2.nbusy));

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover: observed %0d expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
